player_input_ctrl: RTL and testbench

PLAYER_INPUT_CTRL -- requirements
Module: player_input_ctrl

---
 rtl/player_input_ctrl.sv | 172 +++++++++++++++++
 tb/tb_player_input_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_input_ctrl.sv
// Player input controller: synchronised, debounced buttons drive the player column and toggle-encoded missile launches.
// Optional macro PLAYER_AUTOFIRE_EN: a held fire button relaunches every FIRE_COOLDOWN+1 cycles.
module player_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 315000,
   parameter int MOVE_CYCLES     = 250000,
   parameter int MOVE_STEP       = 2,
   parameter int COL_MIN         = 0,
   parameter int COL_MAX         = 609,
   parameter int COL_INIT        = 305,
   parameter int FIRE_COOLDOWN   = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_fire,
   output logic [11:0] btn_col,
   output logic [7:0]  btn_missle_en,
   output logic        fire_pulse,
   output logic [2:0]  missle_idx
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int MV_W = $clog2(MOVE_CYCLES + 1);
   localparam int CD_W = $clog2(FIRE_COOLDOWN + 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, COOLDOWN, WAIT_RELEASE} fire_state_t;

   // Button vectors are ordered {fire, right, left}.
   logic [2:0]        sync1_q;
   logic [2:0]        sync2_q;
   logic [2:0]        deb_q, deb_d;
   logic [DB_W-1:0]   db_cnt_q [3];
   logic [DB_W-1:0]   db_cnt_d [3];
   logic [MV_W-1:0]   mv_cnt_q, mv_cnt_d;
   logic              wrap_s;
   logic [11:0]       col_q, col_d;
   fire_state_t       state_q, state_d;
   logic [CD_W-1:0]   cd_cnt_q, cd_cnt_d;
   logic [7:0]        en_q, en_d;
   logic [2:0]        idx_q, idx_d;
   logic              pulse_q, pulse_d;
   logic              launch_s;

   // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         deb_d[i]    = deb_q[i];
         db_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i]    = ~deb_q[i];
               db_cnt_d[i] = '0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end else begin
            db_cnt_d[i] = '0;
         end
      end
   end

   // Move timer and column stepping; bounds are checked before the step so nothing wraps.
   always_comb begin
      wrap_s   = (mv_cnt_q == MV_W'(MOVE_CYCLES - 1));
      mv_cnt_d = wrap_s ? '0 : mv_cnt_q + MV_W'(1);
      col_d    = col_q;
      if (wrap_s && deb_q[0] && !deb_q[1]) begin
         col_d = (col_q >= 12'(COL_MIN + MOVE_STEP)) ? col_q - 12'(MOVE_STEP) : 12'(COL_MIN);
      end else if (wrap_s && deb_q[1] && !deb_q[0]) begin
         col_d = (({1'b0, col_q} + 13'(MOVE_STEP)) <= 13'(COL_MAX)) ? col_q + 12'(MOVE_STEP)
                                                                      : 12'(COL_MAX);
      end else begin
         col_d = col_q;
      end
   end

   // Fire FSM; outputs of a launch are computed on entry so they appear during the LAUNCH cycle.
   always_comb begin
      state_d  = state_q;
      cd_cnt_d = cd_cnt_q;
      en_d     = en_q;
      idx_d    = idx_q;
      pulse_d  = 1'b0;
      launch_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (deb_q[2]) begin
               launch_s = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         LAUNCH: begin
            state_d  = COOLDOWN;
            cd_cnt_d = CD_W'(FIRE_COOLDOWN - 1);
         end
         COOLDOWN: begin
            if (cd_cnt_q == '0) begin
`ifdef PLAYER_AUTOFIRE_EN
               if (deb_q[2]) begin
                  launch_s = 1'b1;
               end else begin
                  state_d = IDLE;
               end
`else
               state_d = deb_q[2] ? WAIT_RELEASE : IDLE;
`endif
            end else begin
               cd_cnt_d = cd_cnt_q - CD_W'(1);
            end
         end
         WAIT_RELEASE: begin
            if (!deb_q[2]) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_RELEASE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (launch_s) begin
         state_d = LAUNCH;
         pulse_d = 1'b1;
         en_d    = en_q ^ (8'h01 << idx_q);
         idx_d   = idx_q + 3'd1;
      end else begin
         pulse_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 3'b000;
         sync2_q  <= 3'b000;
         deb_q    <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            db_cnt_q[i] <= '0;
         end
         mv_cnt_q <= '0;
         col_q    <= 12'(COL_INIT);
         state_q  <= IDLE;
         cd_cnt_q <= '0;
         en_q     <= 8'h00;
         idx_q    <= 3'd0;
         pulse_q  <= 1'b0;
      end else begin
         sync1_q  <= {btn_fire, btn_right, btn_left};
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         for (int i = 0; i < 3; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
         mv_cnt_q <= mv_cnt_d;
         col_q    <= col_d;
         state_q  <= state_d;
         cd_cnt_q <= cd_cnt_d;
         en_q     <= en_d;
         idx_q    <= idx_d;
         pulse_q  <= pulse_d;
      end
   end

   assign btn_col       = col_q;
   assign btn_missle_en = en_q;
   assign fire_pulse    = pulse_q;
   assign missle_idx    = idx_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: directed scenarios plus random button activity against a behavioural model.
module tb_player_input_ctrl;

   localparam int DEB = 4;
   localparam int MOV = 8;
   localparam int CD  = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_left = 1'b0;
   logic        btn_right = 1'b0;
   logic        btn_fire = 1'b0;
   logic [11:0] btn_col;
   logic [7:0]  btn_missle_en;
   logic        fire_pulse;
   logic [2:0]  missle_idx;

   player_input_ctrl #(
      .DEBOUNCE_CYCLES(DEB), .MOVE_CYCLES(MOV), .FIRE_COOLDOWN(CD)
   ) dut (
      .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
      .btn_col(btn_col), .btn_missle_en(btn_missle_en), .fire_pulse(fire_pulse),
      .missle_idx(missle_idx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int dut_pulses = 0;
   int cyc = 0;
   int last_pulse_cyc = -1;
   int pulse_gap = 0;

   // Behavioural model: button pipeline, debounced levels, column, and launch bookkeeping.
   int m_s1 [3];
   int m_s2 [3];
   int m_deb [3];
   int m_run [3];
   int m_mv, m_col, m_en, m_idx, m_pulse, m_hold;
   bit m_wait;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_edge();
      int raw [3];
      bit do_launch;
      raw = '{btn_left, btn_right, btn_fire};
      do_launch = 1'b0;
      m_pulse = 0;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
         end
         m_mv = 0; m_col = 305; m_en = 0; m_idx = 0; m_hold = 0; m_wait = 1'b0;
      end else begin
         // A launch blocks further decisions for CD+1 edges.
         if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin
`ifdef PLAYER_AUTOFIRE_EN
               do_launch = (m_deb[2] == 1);
`else
               m_wait = (m_deb[2] == 1);
`endif
            end
         end else if (m_wait) begin
            if (m_deb[2] == 0) m_wait = 1'b0;
         end else if (m_deb[2] == 1) begin
            do_launch = 1'b1;
         end
         if (do_launch) begin
            m_en    = m_en ^ (1 << m_idx);
            m_idx   = (m_idx + 1) % 8;
            m_pulse = 1;
            m_hold  = CD + 1;
         end
         if (m_mv == MOV - 1) begin
            if (m_deb[0] == 1 && m_deb[1] == 0) m_col = (m_col - 2 < 0) ? 0 : m_col - 2;
            else if (m_deb[1] == 1 && m_deb[0] == 0) m_col = (m_col + 2 > 609) ? 609 : m_col + 2;
         end
         m_mv = (m_mv + 1) % MOV;
         for (int i = 0; i < 3; i++) begin
            if (m_s2[i] != m_deb[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_deb[i] = 1 - m_deb[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check("col", 32'(btn_col), 32'(m_col));
      check("missle_en", 32'(btn_missle_en), 32'(m_en));
      check("missle_idx", 32'(missle_idx), 32'(m_idx));
      check("fire_pulse", 32'(fire_pulse), 32'(m_pulse));
      if (fire_pulse === 1'b1) begin
         dut_pulses++;
         if (last_pulse_cyc >= 0) pulse_gap = cyc - last_pulse_cyc;
         last_pulse_cyc = cyc;
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      dut_pulses = 0;
      last_pulse_cyc = -1;
      pulse_gap = 0;
   endtask

   initial begin
      logic [7:0] slot_seq [9];
      bit saw_one, saw_608;
      int n, len;
      slot_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE};

      // Reset state, stable with no buttons.
      do_reset();
      check("rst_col", 32'(btn_col), 32'd305);
      check("rst_en", 32'(btn_missle_en), 32'h00);
      check("rst_idx", 32'(missle_idx), 32'd0);
      check("rst_pulse", 32'(fire_pulse), 32'd0);
      ticks(100);
      check("idle_col", 32'(btn_col), 32'd305);
      check("idle_pulses", 32'(dut_pulses), 32'd0);

      // Short glitch is rejected, a long press launches once.
      btn_fire = 1'b1; ticks(3);
      btn_fire = 1'b0; ticks(20);
      check("glitch_pulses", 32'(dut_pulses), 32'd0);
      btn_fire = 1'b1; ticks(20);
      btn_fire = 1'b0; ticks(20);
      check("press_pulses", 32'(dut_pulses), 32'd1);
      check("press_en", 32'(btn_missle_en), 32'h01);
      check("press_idx", 32'(missle_idx), 32'd1);

      // Nine presses walk every slot and wrap.
      do_reset();
      for (int p = 0; p < 9; p++) begin
         btn_fire = 1'b1; ticks(10);
         btn_fire = 1'b0; ticks(25);
         check("slot_en", 32'(btn_missle_en), 32'(slot_seq[p]));
      end
      check("slot_idx", 32'(missle_idx), 32'd1);
      check("slot_pulses", 32'(dut_pulses), 32'd9);

      // Left saturation at 0, then right saturation at 609.
      do_reset();
      saw_one = 1'b0; saw_608 = 1'b0;
      btn_left = 1'b1;
      for (int k = 0; k < 1300; k++) begin
         tick();
         if (btn_col === 12'd1) saw_one = 1'b1;
      end
      check("left_saw_1", 32'(saw_one), 32'd1);
      check("left_sat", 32'(btn_col), 32'd0);
      btn_left = 1'b0; btn_right = 1'b1;
      for (int k = 0; k < 2520; k++) begin
         tick();
         if (btn_col === 12'd608) saw_608 = 1'b1;
      end
      check("right_saw_608", 32'(saw_608), 32'd1);
      check("right_sat", 32'(btn_col), 32'd609);
      btn_right = 1'b0;

      // Both directions held: column holds.
      do_reset();
      btn_left = 1'b1; btn_right = 1'b1; ticks(96);
      check("both_col", 32'(btn_col), 32'd305);
      btn_left = 1'b0; btn_right = 1'b0;

      // Held fire for 50 cycles.
      do_reset();
      btn_fire = 1'b1; ticks(50);
`ifdef PLAYER_AUTOFIRE_EN
      check("auto_many", 32'(dut_pulses >= 3), 32'd1);
      check("auto_gap", 32'(pulse_gap), 32'd11);
`else
      check("hold_once", 32'(dut_pulses), 32'd1);
`endif
      btn_fire = 1'b0; ticks(25);

      // Reset during cooldown aborts; no launch until a fresh press.
      do_reset();
      btn_fire = 1'b1;
      n = 0;
      while (dut_pulses == 0 && n < 40) begin tick(); n++; end
      check("cd_first_launch", 32'(dut_pulses), 32'd1);
      ticks(3);
      btn_fire = 1'b0;
      do_reset();
      ticks(30);
      check("cd_no_launch", 32'(dut_pulses), 32'd0);
      btn_fire = 1'b1; ticks(12);
      btn_fire = 1'b0; ticks(20);
      check("cd_repress", 32'(dut_pulses), 32'd1);
      check("cd_repress_en", 32'(btn_missle_en), 32'h01);

      // Random button activity with occasional resets.
      do_reset();
      n = 0;
      while (n < 1500) begin
         btn_left  = 1'($urandom_range(0, 1));
         btn_right = 1'($urandom_range(0, 1));
         btn_fire  = 1'($urandom_range(0, 1));
         rst       = ($urandom_range(0, 39) == 0);
         len = $urandom_range(1, 20);
         tick();
         rst = 1'b0;
         ticks(len - 1);
         n += len;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
